// File: rtl/xpb_lut_bank.sv
// rtl/xpb_lut_bank.sv - runtime-loadable i*B mod M lookup table with multi-lane 1-cycle reads
// Define XPB_LUT_AUTOFILL_EN to compile in the auto-fill FSM; otherwise the table loads via the write port only.
module xpb_lut_bank #(
  parameter int DATA_W    = 1024,
  parameter int SEL_W     = 5,
  parameter int NUM_LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [SEL_W-1:0]              wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          fill_start,
  input  logic [DATA_W-1:0]             fill_base,
  input  logic [DATA_W-1:0]             fill_mod,
  output logic                          fill_busy,
  output logic                          fill_done,
  output logic                          table_ready,
  input  logic                          lk_valid,
  output logic                          lk_ready,
  input  logic [NUM_LANES*SEL_W-1:0]    lk_sel,
  output logic                          out_valid,
  output logic [NUM_LANES*DATA_W-1:0]   out_data
);
  localparam int DEPTH = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_ADDR = {SEL_W{1'b1}};

  logic [DATA_W-1:0] entry_q [1:DEPTH-1];
  logic [DATA_W-1:0] view    [DEPTH];

  logic              fill_we;
  logic [SEL_W-1:0]  fill_idx;
  logic [DATA_W-1:0] fill_val;
  logic              fill_start_ok;
  logic              fill_ready_set;
  logic              wr_ok;
  logic              lk_acc;

`ifdef XPB_LUT_AUTOFILL_EN
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] b_q, m_q, acc_q;
  logic [SEL_W-1:0]  idx_q;
  logic              busy_q, done_q;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              unused_borrow;

  // One conditional subtract suffices because acc < M and B < M keep sum < 2M.
  always_comb begin
    sum                   = {1'b0, acc_q} + {1'b0, b_q};
    {unused_borrow, diff} = sum - {1'b0, m_q};
    fill_val              = (sum >= {1'b0, m_q}) ? diff : sum[DATA_W-1:0];
  end

  assign fill_start_ok  = (state == IDLE) && fill_start;
  assign fill_we        = (state == FILL);
  assign fill_idx       = idx_q;
  assign fill_ready_set = (state == FILL) && (idx_q == LAST_ADDR);
  assign fill_busy      = busy_q;
  assign fill_done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      b_q    <= '0;
      m_q    <= '0;
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fill_start) begin
          b_q    <= fill_base;
          m_q    <= fill_mod;
          acc_q  <= '0;
          idx_q  <= SEL_W'(1);
          busy_q <= 1'b1;
          state  <= FILL;
        end
        FILL: begin
          acc_q <= fill_val;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST_ADDR) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_fill;
  assign unused_fill    = ^{fill_start, fill_base, fill_mod};
  assign fill_start_ok  = 1'b0;
  assign fill_we        = 1'b0;
  assign fill_idx       = '0;
  assign fill_val       = '0;
  assign fill_ready_set = 1'b0;
  assign fill_busy      = 1'b0;
  assign fill_done      = 1'b0;
`endif

  assign lk_ready = !fill_busy;
  assign wr_ok    = wr_en && !fill_busy;
  assign lk_acc   = lk_valid && lk_ready;

  // Entry 0 is a constant zero; only entries 1..DEPTH-1 are storage.
  always_comb begin
    view[0] = '0;
    for (int i = 1; i < DEPTH; i++) view[i] = entry_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (fill_we && fill_idx == SEL_W'(i))
          entry_q[i] <= fill_val;
        else if (wr_ok && wr_addr == SEL_W'(i))
          entry_q[i] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      table_ready <= 1'b0;
    else if (fill_start_ok)
      table_ready <= 1'b0;
    else if (fill_ready_set || (wr_ok && wr_addr == LAST_ADDR))
      table_ready <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= lk_acc;
      if (lk_acc)
        for (int l = 0; l < NUM_LANES; l++)
          out_data[l*DATA_W +: DATA_W] <= view[lk_sel[l*SEL_W +: SEL_W]];
    end
  end
endmodule

// File: tb/tb_xpb_lut_bank.sv
// tb/tb_xpb_lut_bank.sv - scoreboard bench for xpb_lut_bank (DATA_W=16, SEL_W=3, NUM_LANES=2)
// Exercises auto-fill when XPB_LUT_AUTOFILL_EN is defined, write-port loading otherwise.
module tb_xpb_lut_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        fill_start;
  logic [15:0] fill_base, fill_mod;
  logic        fill_busy, fill_done, table_ready;
  logic        lk_valid, lk_ready;
  logic [5:0]  lk_sel;
  logic        out_valid;
  logic [31:0] out_data;

  xpb_lut_bank #(.DATA_W(16), .SEL_W(3), .NUM_LANES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .fill_start(fill_start), .fill_base(fill_base), .fill_mod(fill_mod),
    .fill_busy(fill_busy), .fill_done(fill_done), .table_ready(table_ready),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_sel(lk_sel),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] tbl40 [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got %h at cycle %0d expected no output", out_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.cyc != cyc || out_data !== e.data) begin
          errors++;
          $display("FAIL lookup: got %h at cycle %0d expected %h at cycle %0d",
                   out_data, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lookup(input logic [2:0] s0, input logic [2:0] s1,
                        input logic [15:0] e0, input logic [15:0] e1);
    exp_t e;
    lk_valid = 1'b1;
    lk_sel   = {s1, s0};
    e.cyc    = cyc + 1;
    e.data   = {e1, e0};
    exp_q.push_back(e);
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
    check({tag, "_out_data"},    out_data,             32'd0);
    check({tag, "_fill_busy"},   {31'd0, fill_busy},   32'd0);
    check({tag, "_fill_done"},   {31'd0, fill_done},   32'd0);
    check({tag, "_table_ready"}, {31'd0, table_ready}, 32'd0);
    check({tag, "_lk_ready"},    {31'd0, lk_ready},    32'd1);
  endtask

`ifdef XPB_LUT_AUTOFILL_EN
  // Runs one fill; with disturb set, holds a write to entry 2 and a lookup across the fill
  // and re-pulses fill_start mid-fill with different operands.
  task automatic run_fill(input logic [15:0] b, input logic [15:0] m, input bit disturb,
                          output int busy_n, output int done_n, output int lkr_bad);
    fill_base  = b;
    fill_mod   = m;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    if (disturb) begin
      wr_en    = 1'b1;
      wr_addr  = 3'd2;
      wr_data  = 16'hBEEF;
      lk_valid = 1'b1;
      lk_sel   = {3'd5, 3'd1};
    end
    busy_n  = 0;
    done_n  = 0;
    lkr_bad = 0;
    for (int n = 0; n < 30; n++) begin
      if (!fill_busy) break;
      busy_n++;
      if (fill_done) done_n++;
      if (lk_ready) lkr_bad++;
      if (disturb && n == 3) begin
        fill_start = 1'b1;
        fill_base  = 16'd1;
        fill_mod   = 16'd3;
      end else begin
        fill_start = 1'b0;
      end
      tick();
    end
    wr_en      = 1'b0;
    lk_valid   = 1'b0;
    fill_start = 1'b0;
    check("fill_terminates", {31'd0, fill_busy}, 32'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_n, done_n, lkr_bad;
    tbl40 = '{16'd0, 16'd40, 16'd80, 16'd23, 16'd63, 16'd6, 16'd46, 16'd86};
    rst_n      = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    fill_start = 1'b0;
    fill_base  = '0;
    fill_mod   = '0;
    lk_valid   = 1'b0;
    lk_sel     = '0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) lookup(3'(i), 3'(7 - i), 16'd0, 16'd0);
    check("empty_table_ready", {31'd0, table_ready}, 32'd0);

`ifdef XPB_LUT_AUTOFILL_EN
    run_fill(16'd40, 16'd97, 1'b1, busy_n, done_n, lkr_bad);
    check("fill_busy_cycles", busy_n, 32'd8);
    check("fill_done_pulses", done_n, 32'd1);
    check("lk_ready_low_in_fill", lkr_bad, 32'd0);
    check("fill_done_cleared", {31'd0, fill_done}, 32'd0);
`else
    fill_base  = 16'd40;
    fill_mod   = 16'd97;
    fill_start = 1'b1;
    tick();
    fill_start = 1'b0;
    tick();
    check("nofill_busy", {31'd0, fill_busy}, 32'd0);
    check("nofill_done", {31'd0, fill_done}, 32'd0);
    check("nofill_lk_ready", {31'd0, lk_ready}, 32'd1);
    for (int i = 1; i < 7; i++) wr(3'(i), tbl40[i]);
    check("ready_before_last", {31'd0, table_ready}, 32'd0);
    wr(3'd7, tbl40[7]);
`endif
    check("table_ready_loaded", {31'd0, table_ready}, 32'd1);
    for (int i = 0; i < 8; i++) lookup(3'(i), 3'(7 - i), tbl40[i], tbl40[7 - i]);

    lookup(3'd3, 3'd6, 16'd23, 16'd46);

    // Same-cycle write returns the old entry.
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 16'h7777;
    lookup(3'd3, 3'd0, 16'd23, 16'd0);
    wr_en   = 1'b0;
    wr(3'd5, 16'h1234);
    wr(3'd0, 16'hFFFF);
    lookup(3'd5, 3'd0, 16'h1234, 16'd0);
    lookup(3'd3, 3'd0, 16'h7777, 16'd0);
    tick();
    tick();
    check("hold_out_valid", {31'd0, out_valid}, 32'd0);
    check("hold_out_data", out_data, {16'd0, 16'h7777});

    // A fill start coinciding with a lookup still serves the current contents.
    fill_base  = 16'd40;
    fill_mod   = 16'd97;
    fill_start = 1'b1;
    lookup(3'd2, 3'd4, 16'd80, 16'd63);
    fill_start = 1'b0;
`ifdef XPB_LUT_AUTOFILL_EN
    check("abort_in_fill", {31'd0, fill_busy}, 32'd1);
    check("abort_ready_cleared", {31'd0, table_ready}, 32'd0);
`endif
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) lookup(3'(i), 3'(7 - i), 16'd0, 16'd0);
    check("post_abort_ready", {31'd0, table_ready}, 32'd0);

`ifdef XPB_LUT_AUTOFILL_EN
    run_fill(16'd5, 16'd7, 1'b0, busy_n, done_n, lkr_bad);
    check("refill_busy_cycles", busy_n, 32'd8);
    check("refill_done_pulses", done_n, 32'd1);
    check("refill_ready", {31'd0, table_ready}, 32'd1);
    lookup(3'd1, 3'd2, 16'd5, 16'd3);
    lookup(3'd3, 3'd4, 16'd1, 16'd6);
    lookup(3'd5, 3'd6, 16'd4, 16'd2);
    lookup(3'd7, 3'd0, 16'd0, 16'd0);
`else
    wr(3'd7, 16'h00AA);
    check("last_write_ready", {31'd0, table_ready}, 32'd1);
    lookup(3'd7, 3'd1, 16'h00AA, 16'd0);
`endif

    tick();
    tick();
    check("lookups_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
